speed_channel_scheduler: RTL and testbench
==========================================

// Module: speed_channel_scheduler
// PURPOSE
//   Shares one phase2speed engine between NCH phase-difference channels (X/Y/Z axes).
//   - Each channel has a one-entry holding slot.
//   - A round-robin FSM issues one slot per transaction to the engine and waits for its ready.
//   - The result is returned on a shared, channel-tagged result bus.
//   Sits between the per-axis Hilbert/phase-difference stages and the speed consumers.
// PARAMETERS
//   NCH      3   number of channels (2..8)
//   PW       19  phase word width, signed
//   SW       16  speed word width, signed Q5.10
//   TIMEOUT  64  max cycles in WAIT before abort (>=2)
//   CW       derived = max(1,$clog2(NCH)), channel index width
// PORTS
//   clock      in   1        system clock, rising edge
//   reset      in   1        asynchronous, active-low; clears all state
//   req_valid  in   NCH      per-channel 1-cycle strobe: new phase sample
//   req_phase  in   NCH*PW   channel i phase at [i*PW +: PW]
//   eng_sample out  1        1-cycle start pulse to phase2speed
//   eng_phase  out  PW       phase to engine; stable from ISSUE through WAIT
//   eng_ready  in   1        engine result-valid pulse
//   eng_speed  in   SW       engine result, sampled when eng_ready=1 in WAIT
//   res_valid  out  1        1-cycle result strobe
//   res_ch     out  CW       channel of res_speed
//   res_speed  out  SW       speed result, held until next res_valid
//   overrun    out  NCH      sticky: slot overwritten before service; cleared only by reset
//   timeout    out  1        1-cycle pulse: transaction aborted
//   busy       out  1        1 when FSM not in IDLE
// BEHAVIOUR
//   Reset (reset=0): all outputs, pending[], slots, rr pointer and grant go to 0; FSM=IDLE.
//     Reset mid-transaction drops the transaction and all pending samples.
//   Slots: req_valid[i] writes req_phase slice i into slot i and sets pending[i].
//     If pending[i] was already 1, the slot is overwritten and overrun[i] is set.
//   FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
//   - IDLE: if any pending, grant = first pending index at or after rr (wrap at NCH).
//     Copy slot[grant] to eng_phase; clear pending[grant]; go to ISSUE.
//     A req_valid for the granted channel in the same cycle: the old value is issued,
//     the new value is stored, pending stays 1, no overrun.
//   - ISSUE: eng_sample=1 for exactly this cycle; go to WAIT; clear the timeout counter.
//   - WAIT: eng_phase held. On eng_ready: capture eng_speed into res_speed, res_ch=grant,
//     go to DONE. Counter increments each WAIT cycle; reaching TIMEOUT without ready
//     pulses timeout, leaves res_* unchanged, sets rr=grant+1 mod NCH, goes to IDLE.
//   - DONE: res_valid=1 for this cycle; rr=grant+1 mod NCH; go to IDLE.
//   eng_ready outside WAIT is ignored. Only one transaction is ever outstanding.
//   Latency, idle scheduler:
//     req_valid in cycle t -> eng_sample in cycle t+2.
//     eng_ready in cycle u -> res_valid in cycle u+1.
//   Fairness: every pending channel is served within NCH transactions.
//   No arithmetic on data; phase/speed pass through bit-exact, sign preserved.
// TESTING
//   1 Single: ch1 req phase=19'h0_1234, engine model ready after 6 cycles returning 16'h0400
//     -> eng_sample at t+2 with eng_phase=19'h01234; res_valid, res_ch=1, res_speed=16'h0400.
//   2 Round-robin: ch0, ch1, ch2 req in the same cycle, rr=0 -> issue order 0,1,2.
//     Then ch0 and ch2 req together with rr=0 -> issue order 0,2. Exactly one res_valid each.
//   3 Overrun: ch2 req 19'h00010 then 19'h00020 while busy on ch0 -> overrun=3'b100;
//     ch2 issued with 19'h00020.
//   4 Timeout: engine never asserts ready -> timeout pulse TIMEOUT cycles after WAIT entry;
//     no res_valid; next pending channel is issued; a late eng_ready is ignored.
//   5 Reset mid-WAIT with ch1 pending, reset low 3 cycles -> busy=0, res_*=0, overrun=0;
//     no eng_sample until a new req arrives.
//   6 Sign/edge: phase 19'h40000 (most negative), speed 16'h8000 -> passed unchanged;
//     NCH=2 wrap of rr from 1 to 0.

Source files
------------

// File: rtl/speed_channel_scheduler_if.sv
// Channel-scheduler bus: per-channel phase requests, the shared phase2speed
// engine handshake, and the channel-tagged result/status outputs.
interface speed_channel_scheduler_if #(
    parameter int NCH = 3,
    parameter int PW  = 19,
    parameter int SW  = 16,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]    req_valid;
    logic [NCH*PW-1:0] req_phase;
    logic              eng_sample;
    logic [PW-1:0]     eng_phase;
    logic              eng_ready;
    logic [SW-1:0]     eng_speed;
    logic              res_valid;
    logic [CW-1:0]     res_ch;
    logic [SW-1:0]     res_speed;
    logic [NCH-1:0]    overrun;
    logic              timeout;
    logic              busy;

    // Environment side: phase producers, the engine and the result consumers.
    modport master (
        output req_valid, req_phase, eng_ready, eng_speed,
        input  eng_sample, eng_phase, res_valid, res_ch, res_speed,
               overrun, timeout, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_phase, eng_ready, eng_speed,
        output eng_sample, eng_phase, res_valid, res_ch, res_speed,
               overrun, timeout, busy
    );
endinterface

// File: rtl/speed_channel_scheduler.sv
// Shares one phase2speed engine between NCH phase-difference channels.
// Each channel owns a one-entry holding slot; a round-robin FSM hands one
// slot at a time to the engine, waits (bounded) for its result and returns
// it on a channel-tagged result bus. Data passes through bit-exact.
module speed_channel_scheduler #(
    parameter int NCH     = 3,
    parameter int PW      = 19,
    parameter int SW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    speed_channel_scheduler_if.slave  bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state, next_state;
    logic [NCH-1:0] pending;
    logic [PW-1:0]  slot [NCH];
    logic [CW-1:0]  rr;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  pick_idx;
    logic           pick_found;
    logic [NCH-1:0] take;
    logic           issue_now;
    logic           capture;
    logic           abort;
    logic [TW-1:0]  wait_cnt;
    logic [PW-1:0]  eng_phase_q;
    logic [CW-1:0]  res_ch_q;
    logic [SW-1:0]  res_speed_q;
    logic [NCH-1:0] overrun_q;
    logic           timeout_q;

    // Round-robin pick: first pending channel at or after rr, wrapping at NCH.
    always_comb begin : pick
        logic [CW:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr} + (CW+1)'(k);
            if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
            if (!pick_found && pending[cand[CW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CW-1:0];
            end
        end
    end

    // One-hot of the channel whose slot is handed to the engine this cycle.
    assign take = issue_now ? (NCH'(1) << pick_idx) : '0;

    // FSM state register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // FSM next-state and per-cycle control strobes.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        issue_now  = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    issue_now  = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                // A ready on the last allowed cycle still wins over the abort.
                if (bus.eng_ready) begin
                    capture    = 1'b1;
                    next_state = ST_DONE;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Holding slots, pending flags and sticky overrun flags.
    // NOTE: the slot array is cleared by reset on purpose: a reset must
    // leave no stale phase that could later be issued to the engine.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            overrun_q <= '0;
            for (int i = 0; i < NCH; i++) slot[i] <= '0;
        end else begin
            // A sample arriving for the channel being granted refills the slot
            // after the old value was copied out, so it is not an overrun.
            pending <= (pending & ~take) | bus.req_valid;
            for (int i = 0; i < NCH; i++) begin
                if (bus.req_valid[i]) begin
                    slot[i] <= bus.req_phase[i*PW +: PW];
                    if (pending[i] && !take[i]) overrun_q[i] <= 1'b1;
                end
            end
        end
    end

    // Transaction datapath: grant, engine phase, wait counter, results, rr.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            rr          <= '0;
            eng_phase_q <= '0;
            wait_cnt    <= '0;
            res_ch_q    <= '0;
            res_speed_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= abort;
            if (issue_now) begin
                grant       <= pick_idx;
                eng_phase_q <= slot[pick_idx];
            end
            if (state == ST_ISSUE)     wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + TW'(1);
            if (capture) begin
                res_speed_q <= bus.eng_speed;
                res_ch_q    <= grant;
            end
            if (abort || state == ST_DONE)
                rr <= (grant == CW'(NCH - 1)) ? '0 : grant + CW'(1);
        end
    end

    assign bus.eng_sample = (state == ST_ISSUE);
    assign bus.eng_phase  = eng_phase_q;
    assign bus.res_valid  = (state == ST_DONE);
    assign bus.res_ch     = res_ch_q;
    assign bus.res_speed  = res_speed_q;
    assign bus.overrun    = overrun_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_speed_channel_scheduler.sv
// Self-checking bench for speed_channel_scheduler: directed scenarios plus
// randomized traffic against a timeline-level reference model (pending set,
// slot values, round-robin pointer and transaction start/end cycles).
module tb_speed_channel_scheduler;
    localparam int NCH     = 3;
    localparam int PW      = 19;
    localparam int SW      = 16;
    localparam int TIMEOUT = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    speed_channel_scheduler_if #(.NCH(NCH), .PW(PW), .SW(SW)) bus ();
    speed_channel_scheduler #(.NCH(NCH), .PW(PW), .SW(SW), .TIMEOUT(TIMEOUT)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    speed_channel_scheduler_if #(.NCH(2), .PW(PW), .SW(SW)) bus2 ();
    speed_channel_scheduler #(.NCH(2), .PW(PW), .SW(SW), .TIMEOUT(4)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [NCH-1:0]  m_pend, m_ovr;
    logic [PW-1:0] m_slot [NCH];
    int            m_rr, m_ch, m_res_ch;
    bit            m_active, m_got;
    longint        m_t_issue, m_t_ready, m_t_idle;
    logic [PW-1:0] m_phase;
    logic [SW-1:0] m_speed, m_res_speed;
    longint        cyc;
    int            lat_q [$];
    logic [SW-1:0] spd_q [$];
    int            stray_mode;

    // Observations of the DUT, for directed checks against constants.
    logic [PW-1:0] obs_issue [$];
    longint        obs_issue_cyc [$];
    int            obs_res_ch [$];
    logic [SW-1:0] obs_res_spd [$];
    longint        obs_to [$];

    function automatic logic [NCH*PW-1:0] ph3(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                                              input logic [PW-1:0] p2);
        return {p2, p1, p0};
    endfunction

    task automatic model_reset();
        m_pend = '0; m_ovr = '0; m_rr = 0; m_ch = 0; m_res_ch = 0;
        m_active = 1'b0; m_got = 1'b0; m_phase = '0; m_speed = '0; m_res_speed = '0;
        for (int i = 0; i < NCH; i++) m_slot[i] = '0;
        lat_q.delete(); spd_q.delete();
        obs_issue.delete(); obs_issue_cyc.delete();
        obs_res_ch.delete(); obs_res_spd.delete(); obs_to.delete();
    endtask

    // Cycles in which the engine's ready is being listened to.
    function automatic bit in_wait(input longint c);
        return m_active && c > m_t_issue && c <= (m_got ? m_t_ready : m_t_issue + TIMEOUT);
    endfunction

    // Advance the model over the end of cycle cyc with this cycle's requests.
    task automatic model_step(input logic [NCH-1:0] rv, input logic [NCH*PW-1:0] rp);
        int ch, lat, r;
        if (m_active && m_got && cyc == m_t_ready) begin
            m_res_ch    = m_ch;
            m_res_speed = m_speed;
        end
        if ((!m_active || cyc >= m_t_idle) && m_pend != '0) begin
            ch = -1;
            for (int k = 0; k < NCH; k++)
                if (ch < 0 && m_pend[(m_rr + k) % NCH]) ch = (m_rr + k) % NCH;
            m_ch = ch; m_phase = m_slot[ch]; m_pend[ch] = 1'b0;
            m_rr = (ch + 1) % NCH;
            if (lat_q.size() > 0) lat = lat_q.pop_front();
            else begin
                r = $urandom_range(0, 19);
                lat = (r == 0) ? TIMEOUT + 1 : (r == 1) ? TIMEOUT : $urandom_range(1, 8);
            end
            m_speed   = (spd_q.size() > 0) ? spd_q.pop_front() : SW'($urandom);
            m_active  = 1'b1;
            m_got     = (lat <= TIMEOUT);
            m_t_issue = cyc + 1;
            m_t_ready = m_t_issue + lat;
            m_t_idle  = m_got ? m_t_ready + 2 : m_t_issue + 1 + TIMEOUT;
        end
        for (int i = 0; i < NCH; i++) begin
            if (rv[i]) begin
                if (m_pend[i]) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_slot[i] = rp[i*PW +: PW];
            end
        end
    endtask

    task automatic check_outputs();
        bit busy_e, samp_e, rv_e, to_e;
        busy_e = m_active && cyc >= m_t_issue && cyc < m_t_idle;
        samp_e = m_active && cyc == m_t_issue;
        rv_e   = m_active && m_got && cyc == m_t_ready + 1;
        to_e   = m_active && !m_got && cyc == m_t_idle;
        check("busy", bus.busy, busy_e);
        check("eng_sample", bus.eng_sample, samp_e);
        check("res_valid", bus.res_valid, rv_e);
        check("timeout", bus.timeout, to_e);
        check("overrun", bus.overrun, m_ovr);
        check("res_ch", bus.res_ch, m_res_ch);
        check("res_speed", bus.res_speed, m_res_speed);
        if (busy_e) check("eng_phase", bus.eng_phase, m_phase);
        if (bus.eng_sample) begin
            obs_issue.push_back(bus.eng_phase);
            obs_issue_cyc.push_back(cyc);
        end
        if (bus.res_valid) begin
            obs_res_ch.push_back(int'(bus.res_ch));
            obs_res_spd.push_back(bus.res_speed);
        end
        if (bus.timeout) obs_to.push_back(cyc);
    endtask

    // One clock cycle: check outputs, drive inputs (engine acts per model plan), advance.
    task automatic do_cycle(input logic [NCH-1:0] rv, input logic [NCH*PW-1:0] rp);
        check_outputs();
        bus.req_valid = rv;
        bus.req_phase = rp;
        bus.eng_speed = SW'($urandom);
        bus.eng_ready = 1'b0;
        if (m_active && m_got && cyc == m_t_ready) begin
            bus.eng_ready = 1'b1;
            bus.eng_speed = m_speed;
        end else if (stray_mode != 0 && !in_wait(cyc)) begin
            bus.eng_ready = (stray_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        model_step(rv, rp);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle('0, '0);
    endtask

    task automatic do_reset();
        bus.req_valid = '0; bus.req_phase = '0; bus.eng_ready = 1'b0; bus.eng_speed = '0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_res_ch", bus.res_ch, '0);
        check("rst_res_speed", bus.res_speed, '0);
        check("rst_overrun", bus.overrun, '0);
        check("rst_eng_phase", bus.eng_phase, '0);
        check("rst_sample", bus.eng_sample, 1'b0);
        model_reset();
        reset = 1'b1;
        cyc += 3;
    endtask

    // ---------------- NCH=2 instance helpers ----------------
    task automatic serve2(input logic [SW-1:0] spd, output logic [PW-1:0] ph,
                          output int rch, output bit ok);
        bit seen;
        ph = '0; rch = -1; ok = 1'b0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus2.eng_sample) begin
                seen = 1'b1;
                ph   = bus2.eng_phase;
            end
            @(posedge clock);
            #1;
        end
        if (seen) begin
            bus2.eng_ready = 1'b1;
            bus2.eng_speed = spd;
            @(posedge clock);
            #1;
            bus2.eng_ready = 1'b0;
            if (bus2.res_valid) begin
                ok  = 1'b1;
                rch = int'(bus2.res_ch);
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0]    rv;
        logic [NCH*PW-1:0] rp;
        logic [PW-1:0]     ph;
        int                rch;
        bit                ok;
        longint            t0;

        bus2.req_valid = '0; bus2.req_phase = '0; bus2.eng_ready = 1'b0; bus2.eng_speed = '0;
        cyc = 0;
        stray_mode = 0;
        @(posedge clock);
        #1;
        do_reset();

        // Single transaction, fixed engine latency.
        lat_q.push_back(6); spd_q.push_back(16'h0400);
        t0 = cyc;
        do_cycle(3'b010, ph3('0, 19'h01234, '0));
        idle(15);
        check("t1_issue_count", obs_issue.size(), 1);
        if (obs_issue.size() > 0) begin
            check("t1_phase", obs_issue[0], 19'h01234);
            check("t1_latency", obs_issue_cyc[0] - t0, 2);
        end
        check("t1_res_count", obs_res_ch.size(), 1);
        if (obs_res_ch.size() > 0) begin
            check("t1_res_ch", obs_res_ch[0], 1);
            check("t1_res_speed", obs_res_spd[0], 16'h0400);
        end

        // Round-robin order from rr=0.
        do_reset();
        lat_q = '{2, 3, 4, 2, 2};
        do_cycle(3'b111, ph3(19'h00100, 19'h00101, 19'h00102));
        idle(30);
        do_cycle(3'b101, ph3(19'h00200, '0, 19'h00202));
        idle(20);
        check("t2_issue_count", obs_issue.size(), 5);
        check("t2_res_count", obs_res_ch.size(), 5);
        if (obs_issue.size() == 5 && obs_res_ch.size() == 5) begin
            check("t2_i0", obs_issue[0], 19'h00100);
            check("t2_i1", obs_issue[1], 19'h00101);
            check("t2_i2", obs_issue[2], 19'h00102);
            check("t2_i3", obs_issue[3], 19'h00200);
            check("t2_i4", obs_issue[4], 19'h00202);
            check("t2_r3", obs_res_ch[3], 0);
            check("t2_r4", obs_res_ch[4], 2);
        end

        // Overrun while busy on channel 0.
        do_reset();
        lat_q = '{10, 2};
        do_cycle(3'b001, ph3(19'h00005, '0, '0));
        idle(3);
        do_cycle(3'b100, ph3('0, '0, 19'h00010));
        do_cycle(3'b100, ph3('0, '0, 19'h00020));
        idle(20);
        check("t3_overrun", bus.overrun, 3'b100);
        check("t3_issue_count", obs_issue.size(), 2);
        if (obs_issue.size() == 2) check("t3_ch2_phase", obs_issue[1], 19'h00020);

        // Timeout, with ready held high whenever the engine is not being waited on.
        do_reset();
        stray_mode = 2;
        lat_q = '{TIMEOUT + 1, 3};
        do_cycle(3'b011, ph3(19'h00007, 19'h00008, '0));
        idle(TIMEOUT + 20);
        stray_mode = 0;
        check("t4_issue_count", obs_issue.size(), 2);
        check("t4_res_count", obs_res_ch.size(), 1);
        check("t4_to_count", obs_to.size(), 1);
        if (obs_issue.size() == 2 && obs_res_ch.size() == 1 && obs_to.size() == 1) begin
            check("t4_next_phase", obs_issue[1], 19'h00008);
            check("t4_res_ch", obs_res_ch[0], 1);
            check("t4_to_cycle", obs_to[0] - obs_issue_cyc[0], TIMEOUT + 1);
        end

        // Reset in the middle of WAIT with channel 1 pending.
        do_reset();
        lat_q = '{2, TIMEOUT + 1}; spd_q.push_back(16'h1234);
        do_cycle(3'b100, ph3('0, '0, 19'h00003));
        idle(8);
        do_cycle(3'b001, ph3(19'h00004, '0, '0));
        idle(3);
        do_cycle(3'b010, ph3('0, 19'h00009, '0));
        do_cycle(3'b010, ph3('0, 19'h0000a, '0));
        idle(2);
        check("t5_pre_overrun", bus.overrun, 3'b010);
        check("t5_pre_busy", bus.busy, 1'b1);
        do_reset();
        idle(12);
        check("t5_no_issue", obs_issue.size(), 0);
        lat_q.push_back(2);
        do_cycle(3'b001, ph3(19'h00055, '0, '0));
        idle(10);
        check("t5_new_issue_count", obs_issue.size(), 1);
        if (obs_issue.size() == 1) check("t5_new_phase", obs_issue[0], 19'h00055);

        // Sign extremes pass through unchanged.
        do_reset();
        lat_q.push_back(2); spd_q.push_back(16'h8000);
        do_cycle(3'b010, ph3('0, 19'h40000, '0));
        idle(8);
        check("t6_issue_count", obs_issue.size(), 1);
        check("t6_res_count", obs_res_spd.size(), 1);
        if (obs_issue.size() == 1 && obs_res_spd.size() == 1) begin
            check("t6_phase", obs_issue[0], 19'h40000);
            check("t6_speed", obs_res_spd[0], 16'h8000);
        end

        // Randomized traffic against the model.
        do_reset();
        stray_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            rv = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
            rp = ph3(PW'($urandom), PW'($urandom), PW'($urandom));
            do_cycle(rv, rp);
        end
        stray_mode = 0;
        idle(2 * TIMEOUT + 20);
        check("rand_drained_busy", bus.busy, 1'b0);

        // NCH=2 instance: rr wraps from 1 back to 0.
        bus2.req_valid = 2'b10;
        bus2.req_phase = {19'h000aa, 19'h00000};
        @(posedge clock);
        #1;
        bus2.req_valid = '0;
        serve2(16'h8000, ph, rch, ok);
        check("n2_a_ok", ok, 1'b1);
        check("n2_a_phase", ph, 19'h000aa);
        check("n2_a_ch", rch, 1);
        check("n2_a_speed", bus2.res_speed, 16'h8000);
        bus2.req_valid = 2'b11;
        bus2.req_phase = {19'h00022, 19'h00011};
        @(posedge clock);
        #1;
        bus2.req_valid = '0;
        serve2(16'h0101, ph, rch, ok);
        check("n2_b_ok", ok, 1'b1);
        check("n2_b_phase", ph, 19'h00011);
        check("n2_b_ch", rch, 0);
        serve2(16'h0202, ph, rch, ok);
        check("n2_c_ok", ok, 1'b1);
        check("n2_c_phase", ph, 19'h00022);
        check("n2_c_ch", rch, 1);
        check("n2_overrun", bus2.overrun, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
